// File: rtl/riscv_if_fetch.sv
// Instruction-fetch stage: owns the fetch PC, keeps at most one imem request in flight,
// and hands {PC, instr} to ID through an output register backed by a 1-entry skid buffer.
module riscv_if_fetch #(
    parameter int unsigned          WORD_SIZE = 32,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    output logic                 imem_req_o,
    output logic [WORD_SIZE-1:0] imem_addr_o,
    input  logic                 imem_gnt_i,
    input  logic                 imem_rvalid_i,
    input  logic [WORD_SIZE-1:0] imem_rdata_i,
    input  logic                 stall_i,
    input  logic                 redirect_i,
    input  logic [WORD_SIZE-1:0] redirect_pc_i,
    output logic [WORD_SIZE-1:0] PC_IF_o,
    output logic [WORD_SIZE-1:0] instr_IF_o,
    output logic                 valid_o
);

    localparam int unsigned W = WORD_SIZE;
    localparam logic [W-1:0] PC_STEP    = W'(4);
    localparam logic [W-1:0] ALIGN_MASK = ~W'(3);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        DROP = 3'd4
    } state_e;

    typedef struct packed {
        logic [W-1:0] pc;
        logic [W-1:0] instr;
    } fetch_pkt_t;

    state_e     state_q, state_d;
    logic [W-1:0] pc_q, pc_d;
    logic [W-1:0] fetch_pc_q, fetch_pc_d;
    fetch_pkt_t out_q, out_d;
    logic       valid_q, valid_d;
    fetch_pkt_t skid_q, skid_d;
    logic       skid_valid_q, skid_valid_d;
    logic       req_q, req_d;
    logic [W-1:0] addr_q, addr_d;

    // State register and all output/data registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            fetch_pc_q   <= '0;
            out_q        <= '0;
            valid_q      <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
            req_q        <= 1'b0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            fetch_pc_q   <= fetch_pc_d;
            out_q        <= out_d;
            valid_q      <= valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
            req_q        <= req_d;
            addr_q       <= addr_d;
        end
    end

    // Next-state, PC, output-slot and skid logic; redirect overrides everything outside IDLE
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        fetch_pc_d   = fetch_pc_q;
        out_d        = out_q;
        valid_d      = valid_q & stall_i;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;

        case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (imem_gnt_i) begin
                    fetch_pc_d = pc_q;
                    pc_d       = pc_q + PC_STEP;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (imem_rvalid_i) begin
                    if (!valid_q || !stall_i) begin
                        out_d   = '{pc: fetch_pc_q, instr: imem_rdata_i};
                        valid_d = 1'b1;
                        state_d = REQ;
                    end else begin
                        skid_d       = '{pc: fetch_pc_q, instr: imem_rdata_i};
                        skid_valid_d = 1'b1;
                        state_d      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!stall_i) begin
                    out_d        = skid_q;
                    valid_d      = 1'b1;
                    skid_valid_d = 1'b0;
                    state_d      = REQ;
                end
            end
            DROP: begin
                if (imem_rvalid_i) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (redirect_i && (state_q != IDLE)) begin
            pc_d         = redirect_pc_i & ALIGN_MASK;
            valid_d      = 1'b0;
            skid_valid_d = 1'b0;
            case (state_q)
                REQ:       state_d = imem_gnt_i ? DROP : REQ;
                WAIT,
                DROP:      state_d = imem_rvalid_i ? REQ : DROP;
                HOLD:      state_d = REQ;
                default:   state_d = IDLE;
            endcase
        end
    end

    // Request/address registers track the state being entered so they line up with REQ
    always_comb begin
        req_d  = (state_d == REQ);
        addr_d = (state_d == REQ) ? pc_d : '0;
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = addr_q;
    assign PC_IF_o     = out_q.pc;
    assign instr_IF_o  = out_q.instr;
    assign valid_o     = valid_q;

    // A response may only arrive while one is expected (or in IDLE, where it is dropped)
    a_no_rvalid_in_req_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        imem_rvalid_i |-> ((state_q != REQ) && (state_q != HOLD)));

    // A redirect always leaves the output slot empty on the following cycle
    a_redirect_kills_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (redirect_i && (state_q != IDLE)) |=> !valid_o);

    // HOLD is only reachable with a filled skid entry
    a_hold_has_skid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == HOLD) |-> skid_valid_q);

endmodule
